// File: rtl/bitonic_drain_if.sv
// rtl/bitonic_drain_if.sv - stream bundle between sorter, drain and consumer
//
// Purpose: carries the wide sorted word from the sorting network into the
// drain, and the serialized record stream from the drain to the consumer.
//
// Signals:
//   din     - sorted wide word, lane i = din[DATW*(i+1)-1 : DATW*i]
//   dinen   - din valid this cycle (single-cycle qualifier, no ready)
//   stall   - registered; the issuer stops issuing while high
//   dot     - serialized record
//   doten   - dot valid
//   dotrdy  - consumer accepts dot this cycle
//   dotlast - dot is the last emitted record of its wide word
//   ovf     - sticky overflow flag
//
// Modports:
//   slave  - the drain itself
//   master - the environment (sorter output + downstream consumer)
interface bitonic_drain_if #(
  parameter int P_LOG = 4,
  parameter int DATW  = 64
);
  logic [(DATW<<P_LOG)-1:0] din;
  logic                     dinen;
  logic                     stall;
  logic [DATW-1:0]          dot;
  logic                     doten;
  logic                     dotrdy;
  logic                     dotlast;
  logic                     ovf;

  modport slave (
    input  din, dinen, dotrdy,
    output stall, dot, doten, dotlast, ovf
  );

  modport master (
    output din, dinen, dotrdy,
    input  stall, dot, doten, dotlast, ovf
  );
endinterface

// File: rtl/bitonic_drain.sv
// rtl/bitonic_drain.sv - wide-word FIFO and record serializer after the bitonic sorter
//
// Purpose: accepts sorted wide words (2^P_LOG records each) into a FIFO,
// then emits one record per cycle on a valid/ready stream, lane 0 first,
// dropping trailing padding records whose key is all-ones. stall is raised
// early enough that words still inside the sorting pipeline fit.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - bitonic_drain_if.slave: din/dinen in, dot/doten/dotlast out with
//          dotrdy in, stall and sticky ovf out
module bitonic_drain #(
  parameter int P_LOG        = 4,
  parameter int DATW         = 64,
  parameter int KEYW         = 32,
  parameter int FDEPTH_LOG   = 5,
  parameter int STALL_MARGIN = 12,
  parameter int DROP_PAD     = 1
) (
  input logic            clk,
  input logic            rst,
  bitonic_drain_if.slave bus
);

  localparam int N     = 1 << P_LOG;
  localparam int DEPTH = 1 << FDEPTH_LOG;
  localparam int WW    = DATW * N;

  localparam logic [FDEPTH_LOG:0] DEPTH_C  = (FDEPTH_LOG+1)'(DEPTH);
  localparam logic [FDEPTH_LOG:0] STALL_TH = (FDEPTH_LOG+1)'(DEPTH - STALL_MARGIN);
  localparam logic [P_LOG-1:0]    LANE_MAX = P_LOG'(N - 1);

  // Wide-word storage and pointers
  logic [WW-1:0]         mem [DEPTH];
  logic [FDEPTH_LOG-1:0] wr_ptr;
  logic [FDEPTH_LOG-1:0] rd_ptr;
  logic [FDEPTH_LOG:0]   count;
  logic [FDEPTH_LOG:0]   count_next;

  // Lane sequencing
  logic [P_LOG-1:0]      lane;
  logic [P_LOG-1:0]      lane_inc;
  logic [WW-1:0]         head;
  logic [DATW-1:0]       lane_rec [N];
  logic [DATW-1:0]       cur_rec;
  logic [DATW-1:0]       nxt_rec;
  logic                  cur_pad;
  logic                  nxt_pad;
  logic                  last;

  // Control
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  out_free;
  logic                  load;
  logic                  skip;

  // Output registers
  logic [DATW-1:0]       dot_r;
  logic                  doten_r;
  logic                  dotlast_r;
  logic                  stall_r;
  logic                  ovf_r;

  function automatic logic is_pad(input logic [DATW-1:0] rec);
    return (DROP_PAD != 0) && (rec[KEYW-1:0] == {KEYW{1'b1}});
  endfunction

  always_comb begin
    full  = (count == DEPTH_C);
    empty = (count == '0);
    // Fullness is judged before any same-cycle pop, so a full FIFO drops
    // the incoming word even if the head leaves this cycle.
    push  = bus.dinen && !full;

    head = mem[rd_ptr];
    for (int i = 0; i < N; i++) begin
      lane_rec[i] = head[i*DATW +: DATW];
    end

    lane_inc = lane + P_LOG'(1);
    cur_rec  = lane_rec[lane];
    // At lane N-1 lane_inc wraps to 0; nxt_pad is then ignored because the
    // lane is last by position anyway.
    nxt_rec  = lane_rec[lane_inc];
    cur_pad  = is_pad(cur_rec);
    nxt_pad  = is_pad(nxt_rec);
    last     = (lane == LANE_MAX) || nxt_pad;

    // The output register may take a new record when it is empty or its
    // current record is being accepted this cycle.
    out_free = !doten_r || bus.dotrdy;

    // A pad is only ever seen at the lane counter when it sits in lane 0
    // (later pads are cut off by 'last'), i.e. the whole word is padding:
    // retire it in one cycle without producing a record.
    skip = out_free && !empty && cur_pad;
    load = out_free && !empty && !cur_pad;
    pop  = skip || (load && last);

    count_next = count + {{FDEPTH_LOG{1'b0}}, push} - {{FDEPTH_LOG{1'b0}}, pop};
  end

  // FIFO storage is not reset; only the pointers and occupancy define content.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lane      <= '0;
      dot_r     <= '0;
      doten_r   <= 1'b0;
      dotlast_r <= 1'b0;
      stall_r   <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FDEPTH_LOG'(1);
      end
      if (bus.dinen && full) begin
        ovf_r <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FDEPTH_LOG'(1);
      end
      count   <= count_next;
      stall_r <= (count_next >= STALL_TH);

      if (load) begin
        dot_r     <= cur_rec;
        doten_r   <= 1'b1;
        dotlast_r <= last;
        lane      <= last ? '0 : lane_inc;
      end else if (skip) begin
        // All-pad word: the previous record (if any) is handed off this
        // cycle and nothing replaces it, giving exactly one bubble.
        doten_r   <= 1'b0;
        dotlast_r <= 1'b0;
        lane      <= '0;
      end else if (out_free) begin
        // Transfer completed (or register already idle) with nothing to load.
        doten_r   <= 1'b0;
        dotlast_r <= 1'b0;
      end
      // Otherwise doten_r=1 and dotrdy=0: hold dot/doten/dotlast stable.
    end
  end

  assign bus.dot     = dot_r;
  assign bus.doten   = doten_r;
  assign bus.dotlast = dotlast_r;
  assign bus.stall   = stall_r;
  assign bus.ovf     = ovf_r;

endmodule
